sd_io_arbiter: RTL and testbench

- Two-requester arbiter for the single SD-card sector I/O channel to the IO controller.
- Requester 0 is the SCSI target's sector engine; requester 1 is the floppy/disk-image engine.
- Grants whole-sector transactions round-robin and latches LBA and direction at grant.
- Steers the shared sector-buffer bus (sd_buff_*) to the granted requester only, and enforces a request-to-ack timeout.

---
 rtl/sd_io_arbiter.sv | 134 +++++++++++++
 tb/tb_sd_io_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_io_arbiter.sv
// rtl/sd_io_arbiter.sv - two-requester round-robin arbiter for the SD sector I/O channel
module sd_io_arbiter #(
    parameter int TMO_W = 20
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] r0_lba,
    input  logic        r0_rd,
    input  logic        r0_wr,
    output logic        r0_ack,
    input  logic [7:0]  r0_buff_din,
    input  logic [31:0] r1_lba,
    input  logic        r1_rd,
    input  logic        r1_wr,
    output logic        r1_ack,
    input  logic [7:0]  r1_buff_din,
    output logic [1:0]  r_buff_wr,
    output logic [31:0] io_lba,
    output logic        io_rd,
    output logic        io_wr,
    input  logic        io_ack,
    input  logic        sd_buff_wr,
    output logic [7:0]  sd_buff_din,
    output logic        grant,
    output logic        busy,
    output logic        tmo_err
);

    typedef enum logic [1:0] {IDLE, REQ, XFER, RELEASE} state_t;

    localparam logic [TMO_W-1:0] CNT_ONE  = {{(TMO_W-1){1'b0}}, 1'b1};
    // Register value on the edge where the count reaches all-ones.
    localparam logic [TMO_W-1:0] CNT_FIRE = {{(TMO_W-1){1'b1}}, 1'b0};

    state_t            state, state_nxt;
    logic              prio, prio_nxt;
    logic              grant_nxt, busy_nxt, tmo_err_nxt;
    logic              io_rd_nxt, io_wr_nxt;
    logic [31:0]       io_lba_nxt;
    logic [TMO_W-1:0]  cnt, cnt_nxt;

    logic              pend0, pend1, sel, sel_rd, sel_wr;
    logic [31:0]       sel_lba;
    logic              in_xfer;

    assign pend0   = r0_rd | r0_wr;
    assign pend1   = r1_rd | r1_wr;
    assign sel     = (pend0 & pend1) ? prio : pend1;
    assign sel_rd  = sel ? r1_rd  : r0_rd;
    assign sel_wr  = sel ? r1_wr  : r0_wr;
    assign sel_lba = sel ? r1_lba : r0_lba;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            prio    <= 1'b0;
            grant   <= 1'b0;
            busy    <= 1'b0;
            tmo_err <= 1'b0;
            io_rd   <= 1'b0;
            io_wr   <= 1'b0;
            io_lba  <= '0;
            cnt     <= '0;
        end else begin
            state   <= state_nxt;
            prio    <= prio_nxt;
            grant   <= grant_nxt;
            busy    <= busy_nxt;
            tmo_err <= tmo_err_nxt;
            io_rd   <= io_rd_nxt;
            io_wr   <= io_wr_nxt;
            io_lba  <= io_lba_nxt;
            cnt     <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        prio_nxt    = prio;
        grant_nxt   = grant;
        busy_nxt    = busy;
        tmo_err_nxt = tmo_err;
        io_rd_nxt   = io_rd;
        io_wr_nxt   = io_wr;
        io_lba_nxt  = io_lba;
        cnt_nxt     = cnt;
        case (state)
            IDLE: begin
                if (pend0 | pend1) begin
                    grant_nxt  = sel;
                    io_lba_nxt = sel_lba;
                    io_rd_nxt  = sel_rd;
                    io_wr_nxt  = sel_wr & ~sel_rd;
                    busy_nxt   = 1'b1;
                    cnt_nxt    = '0;
                    state_nxt  = REQ;
                end
            end
            REQ: begin
                cnt_nxt = cnt + CNT_ONE;
                // An ack arriving on the timeout edge still wins.
                if (io_ack) begin
                    io_rd_nxt = 1'b0;
                    io_wr_nxt = 1'b0;
                    state_nxt = XFER;
                end else if (cnt == CNT_FIRE) begin
                    io_rd_nxt   = 1'b0;
                    io_wr_nxt   = 1'b0;
                    tmo_err_nxt = 1'b1;
                    prio_nxt    = ~grant;
                    busy_nxt    = 1'b0;
                    state_nxt   = IDLE;
                end
            end
            XFER: begin
                if (!io_ack) state_nxt = RELEASE;
            end
            RELEASE: begin
                prio_nxt  = ~grant;
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Ack and buffer strobes reach only the granted requester, and only mid-transfer.
    assign in_xfer     = (state == XFER);
    assign r0_ack      = in_xfer & ~grant & io_ack;
    assign r1_ack      = in_xfer &  grant & io_ack;
    assign r_buff_wr   = {in_xfer & grant & sd_buff_wr, in_xfer & ~grant & sd_buff_wr};
    assign sd_buff_din = grant ? r1_buff_din : r0_buff_din;

endmodule

// File: tb/tb_sd_io_arbiter.sv
// tb/tb_sd_io_arbiter.sv - randomized self-checking bench for sd_io_arbiter
module tb_sd_io_arbiter;

    localparam int TMO_W = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] req_lba [2];
    logic        req_rd  [2];
    logic        req_wr  [2];
    logic [7:0]  req_din [2];
    logic        io_ack, sd_buff_wr;
    logic        r0_ack, r1_ack, io_rd, io_wr, grant, busy, tmo_err;
    logic [1:0]  r_buff_wr;
    logic [31:0] io_lba;
    logic [7:0]  sd_buff_din;

    int  checks = 0;
    int  errors = 0;
    bit  prio_m;
    logic g;
    int  n, hi, bad;
    logic [1:0] seq [4];

    always #5 clk = ~clk;

    sd_io_arbiter #(.TMO_W(TMO_W)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .r0_lba      (req_lba[0]),
        .r0_rd       (req_rd[0]),
        .r0_wr       (req_wr[0]),
        .r0_ack      (r0_ack),
        .r0_buff_din (req_din[0]),
        .r1_lba      (req_lba[1]),
        .r1_rd       (req_rd[1]),
        .r1_wr       (req_wr[1]),
        .r1_ack      (r1_ack),
        .r1_buff_din (req_din[1]),
        .r_buff_wr   (r_buff_wr),
        .io_lba      (io_lba),
        .io_rd       (io_rd),
        .io_wr       (io_wr),
        .io_ack      (io_ack),
        .sd_buff_wr  (sd_buff_wr),
        .sd_buff_din (sd_buff_din),
        .grant       (grant),
        .busy        (busy),
        .tmo_err     (tmo_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Round-robin rule: a lone pending requester wins, otherwise the one matching prio.
    function automatic bit pick();
        bit p0, p1;
        p0 = req_rd[0] | req_wr[0];
        p1 = req_rd[1] | req_wr[1];
        if (p0 && p1) return prio_m;
        return p1;
    endfunction

    task automatic do_reset();
        reset_n    = 1'b0;
        io_ack     = 1'b0;
        sd_buff_wr = 1'b0;
        for (int m = 0; m < 2; m++) begin
            req_rd[m]  = 1'b0;
            req_wr[m]  = 1'b0;
            req_lba[m] = '0;
            req_din[m] = '0;
        end
        prio_m = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_io_req", {io_rd, io_wr}, 0);
        chk("rst_io_lba", io_lba, 0);
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tmo", tmo_err, 0);
        chk("rst_route", {r_buff_wr, r1_ack, r0_ack}, 0);
        reset_n = 1'b1;
    endtask

    // Entered at a negedge in IDLE with the request(s) already presented.
    task automatic serve(input int ack_dly, input int nbytes, output logic gobs);
        bit w;
        logic [31:0] lba;
        logic erd, ewr;
        logic [7:0] din;
        logic [1:0] eack;
        int cyc, good, other, route_bad;
        w    = pick();
        lba  = req_lba[w];
        erd  = req_rd[w];
        ewr  = req_wr[w] & ~req_rd[w];
        din  = req_din[w];
        eack = w ? 2'b10 : 2'b01;
        cyc  = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!(io_rd | io_wr) && cyc < 40);
        gobs = grant;
        chk("grant_latency", cyc, 1);
        chk("grant", grant, w);
        chk("io_lba", io_lba, lba);
        chk("io_rd", io_rd, erd);
        chk("io_wr", io_wr, ewr);
        chk("rd_wr_excl", io_rd & io_wr, 0);
        chk("busy_req", busy, 1);
        route_bad = 0;
        for (int i = 0; i < ack_dly; i++) begin
            @(negedge clk);
            if ({io_rd, io_wr} !== {erd, ewr} || r0_ack || r1_ack) route_bad++;
        end
        chk("req_hold", route_bad, 0);
        io_ack = 1'b1;
        @(negedge clk);
        chk("io_req_drop", {io_rd, io_wr}, 0);
        chk("ack_route", {r1_ack, r0_ack}, eack);
        req_rd[w] = 1'b0;
        req_wr[w] = 1'b0;
        good = 0;
        other = 0;
        route_bad = 0;
        for (int i = 0; i < 2 * nbytes; i++) begin
            sd_buff_wr = (i % 2 == 0);
            #1;
            if (r_buff_wr[w]) good++;
            if (r_buff_wr[!w]) other++;
            if (sd_buff_din !== din || {r1_ack, r0_ack} !== eack) route_bad++;
            @(negedge clk);
        end
        chk("strobes", good, nbytes);
        chk("strobe_other", other, 0);
        chk("xfer_route", route_bad, 0);
        io_ack     = 1'b0;
        sd_buff_wr = 1'b1;
        @(negedge clk);
        chk("rel_busy", busy, 1);
        chk("rel_grant", grant, w);
        chk("rel_quiet", {r_buff_wr, r1_ack, r0_ack}, 0);
        sd_buff_wr = 1'b0;
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_grant", grant, w);
        prio_m = !w;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // Single read, full sector, then prio has moved to requester 1.
        do_reset();
        req_rd[0]  = 1'b1;
        req_lba[0] = 32'h0000_1234;
        req_din[0] = 8'h11;
        serve(3, 512, g);
        chk("t1_grant", g, 0);
        req_rd[0] = 1'b1; req_lba[0] = $urandom;
        req_rd[1] = 1'b1; req_lba[1] = $urandom;
        serve(1, 2, g);
        chk("t1_prio_flip", g, 1);
        serve(1, 2, g);
        chk("t1_leftover", g, 0);

        // Contention straight after reset.
        do_reset();
        req_wr[0] = 1'b1; req_lba[0] = $urandom; req_din[0] = $urandom;
        req_rd[1] = 1'b1; req_lba[1] = $urandom; req_din[1] = $urandom;
        serve(2, 3, g);
        chk("t2_first", g, 0);
        serve(2, 3, g);
        chk("t2_second", g, 1);

        // Fairness with both requesters continuously pending.
        do_reset();
        req_rd[0] = 1'b1; req_lba[0] = $urandom;
        req_wr[1] = 1'b1; req_lba[1] = $urandom;
        for (int k = 0; k < 4; k++) begin
            serve($urandom_range(0, 5), 2, g);
            seq[k] = {1'b0, g};
            req_rd[g]  = !g;
            req_wr[g]  = g;
            req_lba[g] = $urandom;
        end
        chk("t3_seq", {seq[0], seq[1], seq[2], seq[3]}, 8'b00_01_00_01);
        req_rd[0] = 1'b0; req_wr[0] = 1'b0;
        req_rd[1] = 1'b0; req_wr[1] = 1'b0;
        repeat (3) @(negedge clk);

        // Write data steering from requester 1.
        do_reset();
        req_din[0] = 8'h3C;
        req_din[1] = 8'hA5;
        req_wr[1]  = 1'b1;
        req_lba[1] = $urandom;
        serve(2, 6, g);
        chk("t4_grant", g, 1);

        // Randomized traffic against the round-robin model.
        for (int it = 0; it < 24; it++) begin
            for (int m = 0; m < 2; m++) begin
                if (!(req_rd[m] | req_wr[m]) && ($urandom % 2 == 1)) begin
                    logic [1:0] d;
                    d = 2'($urandom_range(1, 3));
                    req_rd[m]  = d[0];
                    req_wr[m]  = d[1];
                    req_lba[m] = $urandom;
                    req_din[m] = 8'($urandom);
                end
            end
            if (!(req_rd[0] | req_wr[0] | req_rd[1] | req_wr[1])) begin
                req_wr[it % 2]  = 1'b1;
                req_lba[it % 2] = $urandom;
            end
            serve($urandom_range(0, 10), $urandom_range(1, 6), g);
        end

        // Ack on the same edge as the timeout count wins.
        do_reset();
        req_rd[0] = 1'b1; req_lba[0] = $urandom;
        serve(14, 2, g);
        chk("t5_coincide_tmo", tmo_err, 0);

        // Timeout, then re-grant of the still-pending requester.
        do_reset();
        req_rd[0] = 1'b1; req_lba[0] = $urandom;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!io_rd && n < 40);
        chk("t5_start", n, 1);
        hi = 0;
        while (io_rd && hi < 40) begin
            hi++;
            @(negedge clk);
        end
        chk("t5_len", hi, 15);
        chk("t5_tmo_err", tmo_err, 1);
        chk("t5_busy", busy, 0);
        prio_m = 1'b1;
        serve(2, 2, g);
        chk("t5_regrant", g, 0);
        chk("t5_sticky", tmo_err, 1);

        // Reset in the middle of a transfer.
        do_reset();
        req_rd[0] = 1'b1; req_lba[0] = $urandom;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!io_rd && n < 40);
        io_ack = 1'b1;
        @(negedge clk);
        chk("t6_ack_pre", {r1_ack, r0_ack}, 2'b01);
        sd_buff_wr = 1'b1;
        #1;
        chk("t6_strobe_pre", r_buff_wr, 2'b01);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_rst_io", {io_rd, io_wr}, 0);
        chk("t6_rst_route", {r_buff_wr, r1_ack, r0_ack}, 0);
        chk("t6_rst_busy", busy, 0);
        req_rd[0] = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if ({r_buff_wr, r1_ack, r0_ack, busy} !== 5'b0) bad++;
        end
        chk("t6_idle_ack_ignored", bad, 0);
        io_ack     = 1'b0;
        sd_buff_wr = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
